cpu_fsm_controller: RTL

- Control-side counterpart of the 16-bit datapath. Holds the instruction register, decodes the instruction and sequences every datapath control input (vsel, writenum, write, readnum, loada, loadb, shift, asel, bsel, ALUop, loadc, loads) through a Moore FSM.
- Handshake with the host: load/in deliver the instruction, s starts execution, w reports idle.

---
 rtl/cpu_ctrl_pkg.sv | 50 +++++
 rtl/cpu_fsm_controller_instr_decoder.sv | 46 ++++
 rtl/vDFFE.sv | 17 +
 rtl/cpu_fsm_controller.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU control FSM and its instruction decoder.
// Optional build macro ILLEGAL_OP_TRAP_EN adds the S_HALT trap state.
package cpu_ctrl_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG
`ifdef ILLEGAL_OP_TRAP_EN
    , S_HALT
`endif
  } state_t;

  // ADD and AND share a path: both read Rn and Rm, then write Rd.
  typedef enum logic [2:0] {
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_ALU_AB,
    CLS_CMP,
    CLS_MVN,
    CLS_UNDEF
  } instr_cls_t;

endpackage

// File: rtl/cpu_fsm_controller_instr_decoder.sv
// Combinational split of the instruction register into operand fields, ALU op and instruction class.
module instr_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int REG_AW = 3
) (
  input  logic [15:0]       i_ir,
  output logic [REG_AW-1:0] o_rn,
  output logic [REG_AW-1:0] o_rd,
  output logic [REG_AW-1:0] o_rm,
  output logic [1:0]        o_sh,
  output logic [1:0]        o_alu_op,
  output logic [WORD_W-1:0] o_sximm8,
  output instr_cls_t        o_cls
);

  logic [2:0] w_opc;
  logic [1:0] w_op;

  assign w_opc    = i_ir[OPC_LSB +: 3];
  assign w_op     = i_ir[OP_LSB +: 2];
  assign o_rn     = i_ir[RN_LSB +: REG_AW];
  assign o_rd     = i_ir[RD_LSB +: REG_AW];
  assign o_rm     = i_ir[RM_LSB +: REG_AW];
  assign o_sh     = i_ir[SH_LSB +: 2];
  assign o_sximm8 = {{(WORD_W-8){i_ir[7]}}, i_ir[7:0]};

  always_comb begin
    o_cls    = CLS_UNDEF;
    o_alu_op = ALU_ADD;
    if (w_opc == OPC_MOV) begin
      if (w_op == OP_MOV_IMM)      o_cls = CLS_MOV_IMM;
      else if (w_op == OP_MOV_REG) o_cls = CLS_MOV_REG;
    end else if (w_opc == OPC_ALU) begin
      // ALU op field maps straight onto the ALU select for this opcode.
      o_alu_op = w_op;
      case (w_op)
        OP_CMP:  o_cls = CLS_CMP;
        OP_MVN:  o_cls = CLS_MVN;
        default: o_cls = CLS_ALU_AB;
      endcase
    end
  end

endmodule

// File: rtl/vDFFE.sv
// Load-enabled register with asynchronous active-low clear.
module vDFFE #(
  parameter int N = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  o_q <= '0;
    else if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/cpu_fsm_controller.sv
// Moore FSM sequencing the 16-bit datapath controls from the instruction register.
// ILLEGAL_OP_TRAP_EN: undefined instructions halt with `illegal` raised instead of acting as NOPs.
module cpu_fsm_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s,
  input  logic              load,
  input  logic [WORD_W-1:0] in,
  output logic              w,
  output logic [WORD_W-1:0] datapath_in,
  output logic              vsel,
  output logic [REG_AW-1:0] writenum,
  output logic              write,
  output logic [REG_AW-1:0] readnum,
  output logic              loada,
  output logic              loadb,
  output logic [1:0]        shift,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        ALUop,
  output logic              loadc,
  output logic              loads
`ifdef ILLEGAL_OP_TRAP_EN
  , output logic            illegal
`endif
);

  state_t            r_state;
  state_t            w_next;
  logic [WORD_W-1:0] r_ir;
  logic              w_ir_en;
  logic [REG_AW-1:0] w_rn, w_rd, w_rm;
  logic [1:0]        w_sh, w_alu_op;
  instr_cls_t        w_cls;

  // IR only captures while idle, so a busy instruction cannot be overwritten.
  assign w_ir_en = load && (r_state == S_WAIT);

  vDFFE #(.N(WORD_W)) u_ir (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_en    (w_ir_en),
    .i_d     (in),
    .o_q     (r_ir)
  );

  instr_decoder #(.WORD_W(WORD_W), .REG_AW(REG_AW)) u_dec (
    .i_ir     (r_ir[15:0]),
    .o_rn     (w_rn),
    .o_rd     (w_rd),
    .o_rm     (w_rm),
    .o_sh     (w_sh),
    .o_alu_op (w_alu_op),
    .o_sximm8 (datapath_in),
    .o_cls    (w_cls)
  );

  assign shift = w_sh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_WAIT;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w        = 1'b0;
    vsel     = 1'b0;
    write    = 1'b0;
    writenum = '0;
    readnum  = '0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    ALUop    = ALU_ADD;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal  = 1'b0;
`endif
    case (r_state)
      S_WAIT: begin
        w = 1'b1;
        if (s) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_cls)
          CLS_MOV_IMM:          w_next = S_WRITE_IMM;
          CLS_MOV_REG, CLS_MVN: w_next = S_GET_B;
          CLS_ALU_AB, CLS_CMP:  w_next = S_GET_A;
`ifdef ILLEGAL_OP_TRAP_EN
          default:              w_next = S_HALT;
`else
          default:              w_next = S_WAIT;
`endif
        endcase
      end
      S_WRITE_IMM: begin
        vsel     = 1'b1;
        write    = 1'b1;
        writenum = w_rn;
        w_next   = S_WAIT;
      end
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
        w_next  = S_GET_B;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
        w_next  = S_ALU;
      end
      S_ALU: begin
        ALUop = w_alu_op;
        asel  = (w_cls == CLS_MOV_REG) || (w_cls == CLS_MVN);
        if (w_cls == CLS_CMP) begin
          loads  = 1'b1;
          w_next = S_WAIT;
        end else begin
          loadc  = 1'b1;
          w_next = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        write    = 1'b1;
        writenum = w_rd;
        w_next   = S_WAIT;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_HALT: illegal = 1'b1;
`endif
      default: w_next = S_WAIT;
    endcase
  end

endmodule
